// File: rtl/tile_blitter.sv
// Tile blitter: reads one 2^TILE_W_LOG2 x 2^TILE_H_LOG2 tile from a fixed-latency ROM and
// streams its pixels (optionally mirrored, colour-keyed) to a ready/valid pixel sink.
module tile_blitter #(
    parameter int                 TILE_W_LOG2 = 3,
    parameter int                 TILE_H_LOG2 = 3,
    parameter int                 ADDR_W      = 12,
    parameter int                 COORD_W     = 8,
    parameter int                 PIXEL_W     = 24,
    parameter int                 ROM_LATENCY = 2,
    parameter bit                 KEY_EN      = 1'b1,
    parameter logic [PIXEL_W-1:0] KEY         = 24'hFF00FF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  tile_base,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               flip_x,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [PIXEL_W-1:0] rom_data,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [PIXEL_W-1:0] px_rgb
);
    localparam int N_LOG2 = TILE_W_LOG2 + TILE_H_LOG2;
    localparam int RET_W  = N_LOG2 + 1;
    localparam int DEPTH  = ROM_LATENCY + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SUM_W  = CNT_W + 2;
    localparam int XY_W   = 2 * COORD_W;
    localparam int ENT_W  = XY_W + PIXEL_W;
    localparam logic [N_LOG2-1:0] LAST_N = {N_LOG2{1'b1}};
    localparam logic [RET_W-1:0]  N_PIX  = {1'b1, {N_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d, rom_addr_q, rom_addr_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic               flip_q, flip_d, busy_q, busy_d, done_q, done_d;
    logic [N_LOG2-1:0]  n_q, n_d;
    logic [RET_W-1:0]   ret_q, ret_d;
    logic [ROM_LATENCY-1:0] pv_q, pv_d;
    logic [XY_W-1:0]    pc_q [ROM_LATENCY];
    logic [XY_W-1:0]    pc_d [ROM_LATENCY];
    logic [ENT_W-1:0]   fifo_q [DEPTH];
    logic [ENT_W-1:0]   fifo_d [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic                   pop_s, push_s, drop_s, key_hit_s, issue_s;
    logic [SUM_W-1:0]       inflight_s, load_s;
    logic [TILE_W_LOG2-1:0] col_s, src_col_s;
    logic [TILE_H_LOG2-1:0] row_s;

    // Datapath: issue throttle, ROM-return tag pipeline and output FIFO bookkeeping.
    always_comb begin
        pop_s     = (cnt_q != '0) && px_ready;
        key_hit_s = KEY_EN && (rom_data == KEY);
        push_s    = pv_q[ROM_LATENCY-1] && !key_hit_s;
        drop_s    = pv_q[ROM_LATENCY-1] && key_hit_s;
        inflight_s = '0;
        for (int k = 0; k < ROM_LATENCY; k++) begin
            inflight_s = inflight_s + SUM_W'(pv_q[k]);
        end
        // Occupancy after this cycle's pop plus reads still in the ROM must leave a free slot.
        load_s  = SUM_W'(cnt_q) - SUM_W'(pop_s) + inflight_s;
        issue_s = (state_q == S_ISSUE) && (load_s < SUM_W'(DEPTH));

        col_s     = n_q[TILE_W_LOG2-1:0];
        row_s     = n_q[N_LOG2-1:TILE_W_LOG2];
        src_col_s = flip_q ? ~col_s : col_s;
        if (issue_s) begin
            rom_addr_d = base_q + ADDR_W'({row_s, src_col_s});
        end else begin
            rom_addr_d = rom_addr_q;
        end

        pv_d[0] = issue_s;
        pc_d[0] = {x0_q + COORD_W'(col_s), y0_q + COORD_W'(row_s)};
        for (int k = 1; k < ROM_LATENCY; k++) begin
            pv_d[k] = pv_q[k-1];
            pc_d[k] = pc_q[k-1];
        end

        fifo_d = fifo_q;
        if (push_s) begin
            fifo_d[wr_q] = {pc_q[ROM_LATENCY-1], rom_data};
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end else begin
            rd_d = rd_q;
        end
        cnt_d = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Control FSM: accept and latch a request, count issued and retired pixels.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        flip_d  = flip_q;
        n_d     = n_q;
        ret_d   = ret_q + RET_W'(pop_s) + RET_W'(drop_s);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    base_d  = tile_base;
                    x0_d    = x_pos;
                    y0_d    = y_pos;
                    flip_d  = flip_x;
                    n_d     = '0;
                    ret_d   = '0;
                end else begin
                    ret_d   = ret_q;
                end
            end
            S_ISSUE: begin
                if (issue_s) begin
                    n_d = n_q + N_LOG2'(1);
                    if (n_q == LAST_N) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    n_d = n_q;
                end
            end
            S_DRAIN: begin
                if (ret_d == N_PIX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Control and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            flip_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            n_q        <= '0;
            ret_q      <= '0;
            rom_addr_q <= '0;
            pv_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            flip_q     <= flip_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            n_q        <= n_d;
            ret_q      <= ret_d;
            rom_addr_q <= rom_addr_d;
            pv_q       <= pv_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    // Pixel payload storage; always qualified by pv_q / cnt_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        fifo_q <= fifo_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = rom_addr_q;
    assign px_valid = (cnt_q != '0);
    assign {px_x, px_y, px_rgb} = fifo_q[rd_q];
endmodule

// File: tb/tb_tile_blitter.sv
// Bench for tile_blitter: tiles with random origins, flips and sink stalls are checked
// against a pixel list built directly from the tile geometry and ROM contents.
`timescale 1ns/1ps
module tb_tile_blitter;
    localparam int AW = 12;
    localparam int CW = 8;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          reset, start, flip_x, busy, done, px_valid, px_ready;
    logic [AW-1:0] tile_base, rom_addr;
    logic [CW-1:0] x_pos, y_pos, px_x, px_y;
    logic [PW-1:0] rom_data, px_rgb;

    int total = 0;
    int bad   = 0;

    logic          key_on   = 1'b0;
    logic [AW-1:0] key_addr = '0;

    logic [39:0]   exp_q[$];
    logic [39:0]   obs_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [AW-1:0] addr_q[$];
    int done_cnt, stall_bad, max_out, timed_out, done_busy_bad, tail_busy_bad;
    int first_cyc, last_cyc;

    tile_blitter dut (
        .clk(clk), .reset(reset), .start(start), .tile_base(tile_base),
        .x_pos(x_pos), .y_pos(y_pos), .flip_x(flip_x), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data), .px_valid(px_valid),
        .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] rom_word(input logic [AW-1:0] a);
        if (key_on && a == key_addr) return 24'hFF00FF;
        return {12'h000, a};
    endfunction

    // ROM with two-cycle latency: address registered on the edge after it appears.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    // Reference: row-major pixel list and address list for one tile.
    task automatic build_exp(input logic [AW-1:0] base, input logic [CW-1:0] x0,
                             input logic [CW-1:0] y0, input logic flip);
        exp_q.delete();
        exp_addr_q.delete();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int src;
                logic [AW-1:0] a;
                logic [PW-1:0] w;
                logic [CW-1:0] px, py;
                src = flip ? 7 - c : c;
                a   = AW'(int'(base) + r * 8 + src);
                w   = rom_word(a);
                px  = CW'(int'(x0) + c);
                py  = CW'(int'(y0) + r);
                exp_addr_q.push_back(a);
                if (w != 24'hFF00FF) exp_q.push_back({px, py, w});
            end
        end
    endtask

    // Drives one request and records everything the sink side observes.
    // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
    task automatic run_tile(input logic [AW-1:0] base, input logic [CW-1:0] x0,
                            input logic [CW-1:0] y0, input logic flip, input int mode,
                            input bit spam, input int abort_n);
        int issued, tail;
        bit seen_done, prev_stall;
        logic [39:0] prev_px;
        logic [AW-1:0] prev_addr;
        obs_q.delete();
        addr_q.delete();
        done_cnt = 0; stall_bad = 0; max_out = 0; timed_out = 0;
        done_busy_bad = 0; tail_busy_bad = 0; first_cyc = -1; last_cyc = -1;
        issued = 0; tail = 0; seen_done = 1'b0; prev_stall = 1'b0; prev_px = '0;
        @(negedge clk);
        tile_base = base; x_pos = x0; y_pos = y0; flip_x = flip; start = 1'b1;
        px_ready  = 1'b1;
        prev_addr = rom_addr;
        if (exp_addr_q.size() > 0 && exp_addr_q[0] == rom_addr) begin
            addr_q.push_back(rom_addr);
            issued = 1;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (rom_addr !== prev_addr) begin
                addr_q.push_back(rom_addr);
                issued++;
                prev_addr = rom_addr;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (busy !== 1'b0) done_busy_bad++;
            end else if (seen_done && busy !== 1'b0) begin
                tail_busy_bad++;
            end
            if (prev_stall && (px_valid !== 1'b1 || {px_x, px_y, px_rgb} !== prev_px)) stall_bad++;
            if (issued - obs_q.size() > max_out) max_out = issued - obs_q.size();
            start = spam && (busy === 1'b1 || done === 1'b1);
            if (start) begin
                tile_base = AW'($urandom); x_pos = CW'($urandom); y_pos = CW'($urandom);
                flip_x = 1'($urandom_range(0, 1));
            end
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = (cyc % 3 == 0);
                default: px_ready = 1'($urandom_range(0, 1));
            endcase
            if (px_valid === 1'b1 && px_ready) begin
                obs_q.push_back({px_x, px_y, px_rgb});
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_stall = (px_valid === 1'b1) && !px_ready;
            prev_px    = {px_x, px_y, px_rgb};
            if (done === 1'b1) seen_done = 1'b1;
            if (abort_n >= 0 && obs_q.size() >= abort_n) break;
            if (seen_done) begin
                tail++;
                if (tail > 4) break;
            end
        end
        if (!seen_done && abort_n < 0) timed_out = 1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; px_ready = 1'b0; flip_x = 1'b0;
        tile_base = '0; x_pos = '0; y_pos = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", px_valid); end
        total++; if (rom_addr !== 12'h000) begin bad++; $display("FAIL reset_addr: got %h want 000", rom_addr); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal();
        int nbad;
        build_exp(12'h100, 8'd10, 8'd20, 1'b0);
        run_tile(12'h100, 8'd10, 8'd20, 1'b0, 0, 1'b0, -1);
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) nbad++;
        total++; if (nbad != 0 || obs_q.size() != 64) begin bad++; $display("FAIL normal_pixels: %0d wrong, got %0d pixels want 64", nbad, obs_q.size()); end
        total++; if (obs_q.size() < 1 || obs_q[0] !== 40'h0A_14_000100) begin bad++; $display("FAIL normal_first: got %h want 0a14000100", (obs_q.size() > 0) ? obs_q[0] : 40'h0); end
        total++; if (obs_q.size() < 64 || obs_q[63] !== 40'h11_1B_00013F) begin bad++; $display("FAIL normal_last: got %0d pixels, want last 111b00013f", obs_q.size()); end
        total++; if (addr_q != exp_addr_q) begin bad++; $display("FAIL normal_addrs: got %0d addresses want %0d in order", addr_q.size(), exp_addr_q.size()); end
        total++; if (done_cnt != 1 || done_busy_bad != 0) begin bad++; $display("FAIL normal_done: got %0d pulses (%0d with busy) want 1", done_cnt, done_busy_bad); end
        total++; if (last_cyc - first_cyc != 63) begin bad++; $display("FAIL normal_rate: got span %0d cycles want 63", last_cyc - first_cyc); end
        total++; if (timed_out != 0) begin bad++; $display("FAIL normal_timeout: got %0d want 0", timed_out); end
    endtask

    task automatic test_flip();
        int nbad;
        build_exp(12'h000, 8'd0, 8'd0, 1'b1);
        run_tile(12'h000, 8'd0, 8'd0, 1'b1, 2, 1'b0, -1);
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) nbad++;
        total++; if (nbad != 0 || obs_q.size() != 64) begin bad++; $display("FAIL flip_pixels: %0d wrong, got %0d pixels want 64", nbad, obs_q.size()); end
        total++; if (obs_q.size() < 8 || obs_q[0] !== 40'h00_00_000007 || obs_q[7] !== 40'h07_00_000000) begin bad++; $display("FAIL flip_row0: got %0d pixels, want (0,0)=007 and (7,0)=000", obs_q.size()); end
        total++; if (done_cnt != 1 || timed_out != 0) begin bad++; $display("FAIL flip_done: got %0d pulses timeout=%0d want 1/0", done_cnt, timed_out); end
    endtask

    task automatic test_backpressure();
        int nbad;
        logic [AW-1:0] b;
        logic [CW-1:0] x, y;
        logic f;
        b = AW'($urandom); x = CW'($urandom); y = CW'($urandom); f = 1'($urandom_range(0, 1));
        build_exp(b, x, y, f);
        run_tile(b, x, y, f, 1, 1'b0, -1);
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) nbad++;
        total++; if (nbad != 0 || obs_q.size() != 64) begin bad++; $display("FAIL bp_pixels: %0d wrong, got %0d pixels want 64", nbad, obs_q.size()); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stall_bad); end
        total++; if (max_out > 3) begin bad++; $display("FAIL bp_inflight: got %0d outstanding want <= 3", max_out); end
        total++; if (done_cnt != 1 || timed_out != 0) begin bad++; $display("FAIL bp_done: got %0d pulses timeout=%0d want 1/0", done_cnt, timed_out); end
    endtask

    task automatic test_transparency();
        int nbad, found;
        key_on = 1'b1; key_addr = 12'h105;
        build_exp(12'h100, 8'd10, 8'd20, 1'b0);
        run_tile(12'h100, 8'd10, 8'd20, 1'b0, 2, 1'b0, -1);
        nbad = 0; found = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) nbad++;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][39:24] == 16'h0F14) found++;
        total++; if (obs_q.size() != 63) begin bad++; $display("FAIL key_count: got %0d transfers want 63", obs_q.size()); end
        total++; if (nbad != 0) begin bad++; $display("FAIL key_pixels: got %0d wrong want 0", nbad); end
        total++; if (found != 0) begin bad++; $display("FAIL key_absent: got %0d pixels at (15,20) want 0", found); end
        total++; if (done_cnt != 1 || timed_out != 0) begin bad++; $display("FAIL key_done: got %0d pulses timeout=%0d want 1/0", done_cnt, timed_out); end
        key_on = 1'b0;
    endtask

    task automatic test_wrap();
        int nbad;
        logic [CW-1:0] y;
        logic [CW-1:0] wx [8];
        wx = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        y = CW'($urandom);
        build_exp(12'hFF8, 8'hFC, y, 1'b0);
        run_tile(12'hFF8, 8'hFC, y, 1'b0, 2, 1'b0, -1);
        nbad = 0;
        for (int i = 0; i < 8; i++) if (i >= obs_q.size() || obs_q[i][39:32] !== wx[i]) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL wrap_x: got %0d wrong px_x of first row want 0", nbad); end
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) nbad++;
        total++; if (nbad != 0 || obs_q.size() != 64) begin bad++; $display("FAIL wrap_pixels: %0d wrong, got %0d pixels want 64", nbad, obs_q.size()); end
        total++; if (addr_q.size() < 9 || addr_q[7] !== 12'hFFF || addr_q[8] !== 12'h000) begin bad++; $display("FAIL wrap_addr: got %0d addresses, want FFF then 000 at 7/8", addr_q.size()); end
        total++; if (done_cnt != 1 || timed_out != 0) begin bad++; $display("FAIL wrap_done: got %0d pulses timeout=%0d want 1/0", done_cnt, timed_out); end
    endtask

    task automatic test_reset_mid();
        int nbad, dcnt;
        build_exp(12'h240, 8'd50, 8'd60, 1'b0);
        run_tile(12'h240, 8'd50, 8'd60, 1'b0, 0, 1'b0, 30);
        reset = 1'b1;
        @(negedge clk);
        total++; if (px_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_outputs: got valid=%b busy=%b done=%b want 0/0/0", px_valid, busy, done); end
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || px_valid !== 1'b0) dcnt++;
        end
        total++; if (dcnt != 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles after abort want 0", dcnt); end
        build_exp(12'h3C0, 8'd100, 8'd200, 1'b1);
        run_tile(12'h3C0, 8'd100, 8'd200, 1'b1, 2, 1'b1, -1);
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) nbad++;
        total++; if (nbad != 0 || obs_q.size() != 64) begin bad++; $display("FAIL second_pixels: %0d wrong, got %0d pixels want 64", nbad, obs_q.size()); end
        total++; if (addr_q != exp_addr_q) begin bad++; $display("FAIL second_addrs: got %0d addresses want %0d in order", addr_q.size(), exp_addr_q.size()); end
        total++; if (done_cnt != 1 || done_busy_bad != 0 || timed_out != 0) begin bad++; $display("FAIL second_done: got %0d pulses timeout=%0d want 1/0", done_cnt, timed_out); end
        total++; if (tail_busy_bad != 0) begin bad++; $display("FAIL second_ignore: got %0d busy cycles after done want 0", tail_busy_bad); end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 4; t++) begin
            int nbad;
            logic [AW-1:0] b;
            logic [CW-1:0] x, y;
            logic f;
            b = AW'($urandom); x = CW'($urandom); y = CW'($urandom); f = 1'($urandom_range(0, 1));
            key_on = (t % 2 == 1);
            key_addr = AW'(int'(b) + int'($urandom_range(0, 63)));
            build_exp(b, x, y, f);
            run_tile(b, x, y, f, t % 3, 1'b0, -1);
            nbad = 0;
            for (int i = 0; i < exp_q.size(); i++) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) nbad++;
            total++; if (nbad != 0 || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b%0d_pixels: %0d wrong, got %0d pixels want %0d", t, nbad, obs_q.size(), exp_q.size()); end
            total++; if (done_cnt != 1 || timed_out != 0 || stall_bad != 0) begin bad++; $display("FAIL b2b%0d_done: got %0d pulses timeout=%0d stalls=%0d want 1/0/0", t, done_cnt, timed_out, stall_bad); end
        end
        key_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_flip();
        test_backpressure();
        test_transparency();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
